// File: rtl/whirlpool_pkg.sv
// Shared types, round constants and byte-layout helpers for the Whirlpool round pipeline.
package whirlpool_pkg;

  localparam int NROUNDS_DEFAULT = 10;
  localparam int RC_ENTRIES      = 11;

  typedef logic [7:0]               wp_byte_t;
  typedef wp_byte_t [0:7][0:7]      wp_matrix_t;
  typedef logic [511:0]             wp_flat_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_FULL1 = 2'd1,
    SKID_FULL2 = 2'd2
  } skid_state_t;

  // Row-0 round constants; entry 0 is zero so round 0 is a pure whitening pass-through.
  localparam logic [63:0] RC_TABLE [0:RC_ENTRIES-1] = '{
    64'h0000000000000000,
    64'h1823c6e887b8014f,
    64'h36a6d2f5796f9152,
    64'h60bc9b8ea30c7b35,
    64'h1de0d7c22e4bfe57,
    64'h157737e59ff04ada,
    64'h58c9290ab1a06b85,
    64'hbd5d10f4cb3e0567,
    64'he427418ba77d95d8,
    64'hfbee7c66dd17479e,
    64'hca2dbf07ad5a8333
  };

  function automatic wp_matrix_t unpack_state(input wp_flat_t s);
    wp_matrix_t m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m[i][j] = s[511-8*(8*i+j) -: 8];
      end
    end
    return m;
  endfunction

  function automatic wp_flat_t pack_state(input wp_matrix_t m);
    wp_flat_t s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        s[511-8*(8*i+j) -: 8] = m[i][j];
      end
    end
    return s;
  endfunction

  // Indices outside the table yield zero.
  function automatic logic [63:0] rc_for_round(input logic [3:0] r);
    logic [63:0] rc;
    rc = '0;
    for (int i = 1; i < RC_ENTRIES; i++) begin
      if (r == 4'(i)) rc = RC_TABLE[i];
    end
    return rc;
  endfunction

endpackage

// File: rtl/whirlpool_skid_buf.sv
// Generic 2-entry valid/ready skid register; in_ready is a flop so upstream never sees a
// combinational path from out_ready.
module whirlpool_skid_buf
  import whirlpool_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             in_ready_q, in_ready_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_valid) begin
          main_d  = in_data;
          state_d = SKID_FULL1;
        end
      end
      SKID_FULL1: begin
        if (in_valid && out_ready) begin
          main_d = in_data;
        end else if (in_valid) begin
          skid_d  = in_data;
          state_d = SKID_FULL2;
        end else if (out_ready) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL2: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = SKID_FULL1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Ready for next cycle is decided from the next state, so it stays a pure register output.
    in_ready_d = (state_d != SKID_FULL2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/whirlpool_stage_addkey.sv
// Registered AddRoundKey stage: XORs the MixRows result with K_r (state path) or with the
// row-0 round constant (key-schedule path), then hands the word to a 2-entry skid buffer.
module whirlpool_stage_addkey
  import whirlpool_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int NROUNDS = NROUNDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_state,
  input  logic [511:0]     in_key,
  input  logic [3:0]       in_round,
  input  logic             in_is_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     out_state,
  output logic [3:0]       out_round,
  output logic             out_is_key,
  output logic             out_last,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
  localparam int         PAYLOAD_W  = 512 + 4 + 1 + 1 + TAG_W;

  logic                 round_err;
  logic                 in_last;
  logic [63:0]          rc;
  wp_matrix_t           key_mat;
  wp_flat_t             result;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 err_q, err_d;

  always_comb begin
    round_err = (in_round > LAST_ROUND);
    in_last   = (in_round == LAST_ROUND);
    rc        = round_err ? 64'h0 : rc_for_round(in_round);
    key_mat   = unpack_state(in_state);
    for (int j = 0; j < 8; j++) begin
      key_mat[0][j] = key_mat[0][j] ^ rc[63-8*j -: 8];
    end
    result     = in_is_key ? pack_state(key_mat) : (in_state ^ in_key);
    in_payload = {result, in_round, in_is_key, in_last, in_tag};
  end

  whirlpool_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  // Error flag is raised for exactly the cycle following the accepting edge.
  always_comb begin
    err_d = in_valid && in_ready && round_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
  assign {out_state, out_round, out_is_key, out_last, out_tag} = out_payload;

endmodule

// File: tb/tb_whirlpool_stage_addkey.sv
// Directed self-checking bench for whirlpool_stage_addkey: reset, both XOR paths, skid
// backpressure, full-rate streaming and out-of-range rounds.
module tb_whirlpool_stage_addkey;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic [511:0] in_key;
  logic [3:0]   in_round;
  logic         in_is_key;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_state;
  logic [3:0]   out_round;
  logic         out_is_key;
  logic         out_last;
  logic [3:0]   out_tag;
  logic         out_err;

  int checks;
  int errors;

  whirlpool_stage_addkey #(
    .TAG_W   (4),
    .NROUNDS (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_key     (in_key),
    .in_round   (in_round),
    .in_is_key  (in_is_key),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_round  (out_round),
    .out_is_key (out_is_key),
    .out_last   (out_last),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_key    = '0;
    in_round  = '0;
    in_is_key = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
    checks++;
    if (out_state !== 512'h0 || out_tag !== 4'h0 || out_round !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_data: got state %h tag %h round %h expected zeros", out_state, out_tag, out_round);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_state_path();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = {64{8'h11}};
    in_key    = {64{8'h22}};
    in_round  = 4'd3;
    in_is_key = 1'b0;
    in_tag    = 4'd5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL state_valid: got %b expected 1", out_valid); end
    checks++;
    if (out_state !== {64{8'h33}}) begin errors++; $display("[TB] FAIL state_xor: got %h expected %h", out_state, {64{8'h33}}); end
    checks++;
    if (out_round !== 4'd3 || out_tag !== 4'd5 || out_last !== 1'b0 || out_is_key !== 1'b0) begin
      errors++; $display("[TB] FAIL state_side: got round %0d tag %0d last %b key %b expected 3 5 0 0", out_round, out_tag, out_last, out_is_key);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL state_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_key_path();
    logic [3:0]  rounds [3];
    logic [63:0] rcs    [3];
    logic        lasts  [3];
    rounds = '{4'd1, 4'd10, 4'd0};
    rcs    = '{64'h1823c6e887b8014f, 64'hca2dbf07ad5a8333, 64'h0};
    lasts  = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in_state  = '0;
      in_key    = {64{8'hff}};
      in_round  = rounds[k];
      in_is_key = 1'b1;
      in_tag    = 4'(k + 8);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_state !== {rcs[k], 448'h0}) begin
        errors++; $display("[TB] FAIL key_rc_r%0d: got %h expected %h", rounds[k], out_state, {rcs[k], 448'h0});
      end
      checks++;
      if (out_valid !== 1'b1 || out_last !== lasts[k] || out_is_key !== 1'b1 || out_round !== rounds[k]) begin
        errors++; $display("[TB] FAIL key_side_r%0d: got valid %b last %b key %b round %0d expected 1 %b 1 %0d",
                           rounds[k], out_valid, out_last, out_is_key, out_round, lasts[k], rounds[k]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [511:0] held;
    out_ready = 1'b0;
    in_is_key = 1'b0;
    in_key    = '0;
    in_round  = 4'd2;
    in_valid  = 1'b1;
    in_state  = {64{8'h01}};
    in_tag    = 4'd1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd1 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_first: got valid %b tag %0d ready %b expected 1 1 1", out_valid, out_tag, in_ready);
    end
    held      = out_state;
    in_state  = {64{8'h02}};
    in_tag    = 4'd2;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 4'd1) begin
      errors++; $display("[TB] FAIL bp_second: got ready %b tag %0d expected 0 1", in_ready, out_tag);
    end
    in_state = {64{8'h03}};
    in_tag   = 4'd3;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 4'd1 || out_state !== held || out_state !== {64{8'h01}}) begin
      errors++; $display("[TB] FAIL bp_stable: got ready %b tag %0d state %h expected 0 1 %h", in_ready, out_tag, out_state, {64{8'h01}});
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd2 || out_state !== {64{8'h02}} || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_drain1: got valid %b tag %0d ready %b expected 1 2 1", out_valid, out_tag, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_state !== {64{8'h03}}) begin
      errors++; $display("[TB] FAIL bp_third: got valid %b tag %0d expected 1 3", out_valid, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_is_key = 1'b0;
    in_key    = {64{8'ha5}};
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_state = {64{8'(i)}};
      in_round = 4'(i % 11);
      in_tag   = 4'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'(i) || out_state !== {64{8'(i) ^ 8'ha5}} ||
          out_last !== ((i % 11) == 10) || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_word%0d: got valid %b tag %0d last %b ready %b byte %h expected 1 %0d %b 1 %h",
                           i, out_valid, out_tag, out_last, in_ready, out_state[7:0], i, ((i % 11) == 10), 8'(i) ^ 8'ha5);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b expected 0", out_valid); end
  endtask

  task automatic test_error();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = {8{64'h0123456789abcdef}};
    in_key    = {64{8'h5a}};
    in_round  = 4'd12;
    in_is_key = 1'b1;
    in_tag    = 4'd9;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL err_pulse: got %b expected 1", out_err); end
    checks++;
    if (out_state !== {8{64'h0123456789abcdef}} || out_valid !== 1'b1 || out_round !== 4'd12 || out_last !== 1'b0) begin
      errors++; $display("[TB] FAIL err_passthru: got %h round %0d expected %h round 12", out_state, out_round, {8{64'h0123456789abcdef}});
    end
    tick();
    checks++;
    if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL err_single: got %b expected 0", out_err); end
    in_valid = 1'b1;
    in_round = 4'd10;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL err_inrange: got %b expected 0", out_err); end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_is_key = 1'b0;
    in_key    = '0;
    in_round  = 4'd4;
    in_valid  = 1'b1;
    in_state  = {64{8'h77}};
    in_tag    = 4'd7;
    tick();
    in_tag = 4'd8;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_full2: got ready %b valid %b expected 0 1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_async: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL rst_stale%0d: got valid %b ready %b expected 0 1", c, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_state_path();
    test_key_path();
    test_backpressure();
    test_back_to_back();
    test_error();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
